dm_wait_responder: RTL and testbench
====================================

// Module: dm_wait_responder
// PURPOSE
//  Memory-side responder for the CPU data-memory request interface
//  (we / addr / wdata / DMType). Unlike the zero-latency dm, it models a
//  slow data RAM: it accepts one request, inserts a programmable number of
//  wait states, then completes with a ready pulse. While a request is
//  pending it drives busy, which the pipeline uses as its memory-stage stall.
//  It performs byte/halfword/word lane steering with load sign/zero
//  extension, and flags misaligned accesses.
// PARAMETERS
//  ADDR_BITS    7  word-index width; RAM depth = 2**ADDR_BITS words
//  WAIT_CYCLES  2  wait states before completion, range 0..15
// PORTS
//  clk           in   1   CPU clock, rising edge
//  rst           in   1   asynchronous active-high reset
//  req           in   1   request valid; held by the CPU until ready
//  we            in   1   1 = store, 0 = load
//  dm_type       in   3   000 word, 001 half, 010 half-u, 011 byte, 100 byte-u
//  addr          in   32  byte address
//  wdata         in   32  store data, right-aligned
//  rdata         out  32  load result, extended; valid only while ready=1
//  ready         out  1   one-cycle completion pulse
//  busy          out  1   stall request = req & ~ready
//  err           out  1   misaligned or illegal dm_type; valid with ready
//  mem_addr_out  out  32  latched request address, for debug
//  mem_data_out  out  32  wdata when latched we=1, else rdata; for debug
// BEHAVIOUR
//  - Reset (async): state IDLE, counter 0, all latches 0. rdata, ready, err,
//    mem_addr_out and mem_data_out are 0. busy follows req. RAM contents
//    are not cleared.
//  - FSM states: IDLE, WAIT, DONE.
//  - IDLE: if req=1 at a clock edge, latch we, dm_type, addr and wdata.
//    Then go to WAIT with cnt = WAIT_CYCLES-1, or to DONE if WAIT_CYCLES=0.
//  - WAIT: decrement cnt each cycle; go to DONE when cnt = 0.
//  - DONE: ready=1 for exactly one cycle, then always return to IDLE.
//  - Latency: ready is asserted WAIT_CYCLES+1 cycles after the edge that
//    sampled req.
//  - Back-to-back: req=1 in the IDLE cycle after DONE is a new request.
//    Worst-case throughput is one access per WAIT_CYCLES+2 cycles.
//  - Inputs are ignored outside IDLE; only the latched values are used.
//  - Word index = addr[ADDR_BITS+1:2]. Upper address bits are ignored, so
//    addresses alias (wrap) modulo the RAM size.
//  - Store: byte-lane write enables are computed from dm_type and addr[1:0].
//    The RAM word is updated on the edge that ends DONE.
//    * byte: wdata[7:0] goes to lane addr[1:0].
//    * half: wdata[15:0] goes to lanes {addr[1],0} and {addr[1],1}.
//    * word: all four lanes are written.
//  - Load: rdata is formed combinationally in DONE from the RAM word.
//    * The selected lane or half is shifted down to bit 0.
//    * Codes 001 and 011 sign-extend; 010 and 100 zero-extend.
//  - Error cases: half with addr[0]=1; word with addr[1:0]!=0; dm_type of
//    101..111. Each still completes normally with ready, and gives err=1,
//    rdata=0 and no RAM write.
//  - A load returns the data of every earlier completed store.
//  - Reset mid-operation (WAIT or DONE) returns to IDLE immediately.
//    No write is committed, and no ready pulse is produced.
// TESTING
//  1 WAIT=2. sw 0x12345678 @0x10, then lw @0x10.
//    -> ready 3 cycles after each sample; busy high until then;
//       rdata=0x12345678.
//  2 sb 0xAB @0x11, then loads.
//    -> lw @0x10 = 0x1234AB78; lb @0x11 = 0xFFFFFFAB; lbu @0x11 = 0x000000AB.
//  3 sh 0x8001 @0x12, then loads.
//    -> lw @0x10 = 0x8001AB78; lh @0x12 = 0xFFFF8001; lhu @0x12 = 0x00008001.
//  4 lw @0x13 -> err=1, rdata=0. sw 0xFFFFFFFF @0x11 -> err=1; the word at
//    0x10 is unchanged. dm_type=111 -> err=1.
//  5 WAIT=0, ADDR_BITS=7. sw 0xCAFEF00D @0x204, held req -> ready on the 2nd
//    cycle; repeat back-to-back. Then lw @0x004 -> 0xCAFEF00D (aliasing).
//  6 Assert rst during WAIT of sw 0xDEADBEEF @0x10 -> ready/err/rdata go to 0
//    at once; a following lw @0x10 returns the prior value 0x8001AB78.

Source files
------------

// File: rtl/dm_wait_responder_if.sv
// Data-memory request bus between the CPU memory stage (master) and a
// wait-state memory responder (slave); dbg_state exposes the responder FSM.
interface dm_wait_responder_if;
    logic        req;
    logic        we;
    logic [2:0]  dm_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_data_out;
    logic [1:0]  dbg_state;

    // Handshake: the master raises req with we/dm_type/addr/wdata stable and
    // holds it until ready; ready is a one-cycle completion pulse, and rdata/err
    // are valid only while ready=1. busy = req & ~ready is the pipeline stall.
    modport master (
        output req, we, dm_type, addr, wdata,
        input  rdata, ready, busy, err, mem_addr_out, mem_data_out, dbg_state
    );

    modport slave (
        input  req, we, dm_type, addr, wdata,
        output rdata, ready, busy, err, mem_addr_out, mem_data_out, dbg_state
    );
endinterface

// File: rtl/dm_wait_responder.sv
// Slow data-RAM responder: latches one request, waits WAIT_CYCLES cycles,
// then completes with a ready pulse, doing byte/half/word lane steering.
module dm_wait_responder #(
    parameter int ADDR_BITS   = 7,
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    dm_wait_responder_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        l_we;
    logic [2:0]  l_type;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            l_we    <= 1'b0;
            l_type  <= 3'd0;
            l_addr  <= 32'd0;
            l_wdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        l_we    <= bus.we;
                        l_type  <= bus.dm_type;
                        l_addr  <= bus.addr;
                        l_wdata <= bus.wdata;
                        if (WAIT_CYCLES == 0) begin
                            state <= DONE;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= DONE;
                    else             cnt   <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [ADDR_BITS-1:0] word_idx;
    logic [1:0]           lane;
    logic                 is_word;
    logic                 is_half;
    logic                 is_byte;
    logic                 bad;
    logic                 done;

    assign word_idx = l_addr[ADDR_BITS+1:2];
    assign lane     = l_addr[1:0];
    assign is_word  = (l_type == 3'b000);
    assign is_half  = (l_type == 3'b001) || (l_type == 3'b010);
    assign is_byte  = (l_type == 3'b011) || (l_type == 3'b100);
    assign bad      = (is_half & lane[0]) | (is_word & (lane != 2'b00)) | (l_type > 3'd4);
    assign done     = (state == DONE);

    // Store data is replicated across lanes so the byte enables alone select it.
    logic [3:0]  be;
    logic [31:0] wlanes;

    always_comb begin
        be     = 4'b0000;
        wlanes = l_wdata;
        if (is_byte) begin
            be     = 4'b0001 << lane;
            wlanes = {4{l_wdata[7:0]}};
        end else if (is_half) begin
            be     = lane[1] ? 4'b1100 : 4'b0011;
            wlanes = {2{l_wdata[15:0]}};
        end else if (is_word) begin
            be     = 4'b1111;
        end
    end

    always_ff @(posedge clk) begin
        if (done && l_we && !bad) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    logic [31:0] rword;
    logic [31:0] shifted;
    logic [31:0] load_val;

    assign rword   = mem[word_idx];
    assign shifted = rword >> {lane, 3'b000};

    always_comb begin
        case (l_type)
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_val = {16'd0, shifted[15:0]};
            3'b011:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_val = {24'd0, shifted[7:0]};
            default: load_val = shifted;
        endcase
    end

    assign bus.rdata        = (done && !l_we && !bad) ? load_val : 32'd0;
    assign bus.ready        = done;
    assign bus.err          = done & bad;
    assign bus.busy         = bus.req & ~done;
    assign bus.mem_addr_out = l_addr;
    assign bus.mem_data_out = l_we ? l_wdata : bus.rdata;
    assign bus.dbg_state    = state;
endmodule

// File: tb/tb_dm_wait_responder.sv
// Bench for dm_wait_responder: directed spec scenarios plus random accesses
// checked against a byte-addressed memory model.
module tb_dm_wait_responder;
    localparam int AB     = 7;
    localparam int WA     = 2;
    localparam int WB     = 0;
    localparam int NBYTES = 4 * (2 ** AB);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_a, req_b, t_we, sel_cur;
    logic [2:0]  t_type;
    logic [31:0] t_addr, t_wdata;

    dm_wait_responder_if ifa();
    dm_wait_responder_if ifb();

    assign ifa.req = req_a;  assign ifa.we = t_we;  assign ifa.dm_type = t_type;
    assign ifa.addr = t_addr;  assign ifa.wdata = t_wdata;
    assign ifb.req = req_b;  assign ifb.we = t_we;  assign ifb.dm_type = t_type;
    assign ifb.addr = t_addr;  assign ifb.wdata = t_wdata;

    dm_wait_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(WA)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    dm_wait_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(WB)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    logic        o_ready, o_busy, o_err;
    logic [31:0] o_rdata, o_maddr, o_mdata;
    assign o_ready = sel_cur ? ifb.ready        : ifa.ready;
    assign o_busy  = sel_cur ? ifb.busy         : ifa.busy;
    assign o_err   = sel_cur ? ifb.err          : ifa.err;
    assign o_rdata = sel_cur ? ifb.rdata        : ifa.rdata;
    assign o_maddr = sel_cur ? ifb.mem_addr_out : ifa.mem_addr_out;
    assign o_mdata = sel_cur ? ifb.mem_data_out : ifa.mem_data_out;

    int tests_run = 0;
    int fails     = 0;
    logic [7:0] model [2][NBYTES];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_err(input logic [2:0] ty, input logic [31:0] a);
        return (ty > 3'd4) || ((ty == 3'd1 || ty == 3'd2) && a[0]) || (ty == 3'd0 && a[1:0] != 2'b00);
    endfunction

    function automatic int model_size(input logic [2:0] ty);
        if (ty == 3'd0) return 4;
        if (ty == 3'd1 || ty == 3'd2) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] model_load(input bit sel, input logic [2:0] ty, input int base);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < model_size(ty); i++) v[8*i +: 8] = model[sel][base + i];
        if (ty == 3'd1 && v[15]) v[31:16] = 16'hFFFF;
        if (ty == 3'd3 && v[7])  v[31:8]  = 24'hFFFFFF;
        return v;
    endfunction

    // One complete transaction; inputs are scrambled after the sampling edge
    // since the responder must work only from what it latched.
    task automatic access(input bit sel, input logic w, input logic [2:0] ty,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
        int lat;
        bit seen, busy_ok, exp_err;
        int base;
        logic [31:0] exp_rd;
        exp_err = model_err(ty, a);
        base    = int'(a[AB+1:0]);
        exp_rd  = (exp_err || w) ? 32'd0 : model_load(sel, ty, base);
        sel_cur = sel;
        t_we = w;  t_type = ty;  t_addr = a;  t_wdata = wd;
        if (sel) req_b = 1'b1; else req_a = 1'b1;
        @(posedge clk);
        #1;
        t_we = 1'($urandom);  t_type = 3'($urandom);  t_addr = $urandom;  t_wdata = $urandom;
        lat = 0;  seen = 0;  busy_ok = 1;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (o_ready === 1'b1) seen = 1;
            else if (o_busy !== 1'b1) busy_ok = 0;
        end
        chk("latency", 32'(lat), 32'((sel ? WB : WA) + 1));
        chk("busy_while_pending", 32'(busy_ok), 32'd1);
        chk("busy_at_ready", 32'(o_busy), 32'd0);
        chk("err", 32'(o_err), 32'(exp_err));
        chk("mem_addr_out", o_maddr, a);
        if (!w) chk("rdata", o_rdata, exp_rd);
        chk("mem_data_out", o_mdata, w ? wd : exp_rd);
        rd = o_rdata;
        er = o_err;
        if (w && !exp_err)
            for (int i = 0; i < model_size(ty); i++) model[sel][base + i] = wd[8*i +: 8];
        @(negedge clk);
        chk("ready_one_cycle", 32'(o_ready), 32'd0);
        if (sel) req_b = 1'b0; else req_a = 1'b0;
    endtask

    // Starts a store on instance A and hits reset after 'cycles' negedges.
    task automatic store_then_reset(input int cycles, input logic [31:0] a, input logic [31:0] wd);
        sel_cur = 1'b0;
        t_we = 1'b1;  t_type = 3'd0;  t_addr = a;  t_wdata = wd;
        req_a = 1'b1;
        @(posedge clk);
        repeat (cycles) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(o_ready), 32'd0);
        chk("rst_mid_err", 32'(o_err), 32'd0);
        chk("rst_mid_rdata", o_rdata, 32'd0);
        chk("rst_mid_maddr", o_maddr, 32'd0);
        chk("rst_mid_mdata", o_mdata, 32'd0);
        req_a = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        w;
        logic [2:0]  ty;
        logic [31:0] a;

        rst = 1'b1;  req_a = 1'b0;  req_b = 1'b0;  sel_cur = 1'b0;
        t_we = 1'b0;  t_type = 3'd0;  t_addr = 32'd0;  t_wdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset_ready", 32'(o_ready), 32'd0);
        chk("reset_err", 32'(o_err), 32'd0);
        chk("reset_rdata", o_rdata, 32'd0);
        chk("reset_maddr", o_maddr, 32'd0);
        chk("reset_mdata", o_mdata, 32'd0);
        chk("reset_busy_idle", 32'(o_busy), 32'd0);
        req_a = 1'b1;
        #1;
        chk("reset_busy_follows_req", 32'(o_busy), 32'd1);
        req_a = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 2 ** AB; i++) access(1'b0, 1'b1, 3'd0, 32'(i * 4), 32'd0, rd, er);

        // Scenario 1: word store and load
        access(1'b0, 1'b1, 3'd0, 32'h10, 32'h12345678, rd, er);
        access(1'b0, 1'b0, 3'd0, 32'h10, 32'd0, rd, er);
        chk("t1_lw", rd, 32'h12345678);

        // Scenario 2: byte store, then word/byte loads
        access(1'b0, 1'b1, 3'd3, 32'h11, 32'h555555AB, rd, er);
        access(1'b0, 1'b0, 3'd0, 32'h10, 32'd0, rd, er);
        chk("t2_lw", rd, 32'h1234AB78);
        access(1'b0, 1'b0, 3'd3, 32'h11, 32'd0, rd, er);
        chk("t2_lb", rd, 32'hFFFFFFAB);
        access(1'b0, 1'b0, 3'd4, 32'h11, 32'd0, rd, er);
        chk("t2_lbu", rd, 32'h000000AB);

        // Scenario 3: halfword store, then loads
        access(1'b0, 1'b1, 3'd1, 32'h12, 32'h77778001, rd, er);
        access(1'b0, 1'b0, 3'd0, 32'h10, 32'd0, rd, er);
        chk("t3_lw", rd, 32'h8001AB78);
        access(1'b0, 1'b0, 3'd1, 32'h12, 32'd0, rd, er);
        chk("t3_lh", rd, 32'hFFFF8001);
        access(1'b0, 1'b0, 3'd2, 32'h12, 32'd0, rd, er);
        chk("t3_lhu", rd, 32'h00008001);

        // Scenario 4: error cases
        access(1'b0, 1'b0, 3'd0, 32'h13, 32'd0, rd, er);
        chk("t4_lw_mis_err", 32'(er), 32'd1);
        chk("t4_lw_mis_rdata", rd, 32'd0);
        access(1'b0, 1'b1, 3'd0, 32'h11, 32'hFFFFFFFF, rd, er);
        chk("t4_sw_mis_err", 32'(er), 32'd1);
        access(1'b0, 1'b0, 3'd0, 32'h10, 32'd0, rd, er);
        chk("t4_word_unchanged", rd, 32'h8001AB78);
        access(1'b0, 1'b0, 3'd7, 32'h10, 32'd0, rd, er);
        chk("t4_type7_err", 32'(er), 32'd1);

        // Scenario 5: zero wait states, back-to-back, address aliasing
        access(1'b1, 1'b1, 3'd0, 32'h204, 32'hCAFEF00D, rd, er);
        access(1'b1, 1'b1, 3'd0, 32'h204, 32'hCAFEF00D, rd, er);
        access(1'b1, 1'b0, 3'd0, 32'h004, 32'd0, rd, er);
        chk("t5_alias", rd, 32'hCAFEF00D);

        // Scenario 6: reset during WAIT and during DONE drops the store
        store_then_reset(1, 32'h10, 32'hDEADBEEF);
        access(1'b0, 1'b0, 3'd0, 32'h10, 32'd0, rd, er);
        chk("t6_after_rst_wait", rd, 32'h8001AB78);
        store_then_reset(WA + 1, 32'h10, 32'hDEADBEEF);
        access(1'b0, 1'b0, 3'd0, 32'h10, 32'd0, rd, er);
        chk("t6_after_rst_done", rd, 32'h8001AB78);

        // Random accesses against the byte model, biased toward legal alignment
        for (int n = 0; n < 150; n++) begin
            w  = 1'($urandom_range(0, 1));
            ty = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (ty == 3'd0) a[1:0] = 2'b00;
                else if (ty == 3'd1 || ty == 3'd2) a[0] = 1'b0;
            end
            access(1'b0, w, ty, a, $urandom, rd, er);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
